// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the push-button conditioner
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // Board buttons pull low when pressed
    localparam logic KEY_PRESSED_LEVEL = 1'b0;

    localparam int DEFAULT_DEBOUNCE_CYCLES     = 250000;
    localparam int DEFAULT_REPEAT_DELAY_CYCLES = 10000000;
    localparam int DEFAULT_REPEAT_RATE_CYCLES  = 2500000;
    localparam int DEFAULT_REPEAT_EN           = 1;
    localparam int DEFAULT_CNT_W               = 24;

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - synchronizer, debounce and hold-to-repeat pulse for one key
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES,
    parameter int REPEAT_EN           = DEFAULT_REPEAT_EN,
    parameter int CNT_W               = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic level_next,
    output logic pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    rpt_state_e       state_q, state_d;
    logic             pulse_q, pulse_d;
    logic             p;

    always_comb begin
        s1_d     = key_raw;
        s2_d     = s1_q;
        p        = (s2_q == KEY_PRESSED_LEVEL);
        stable_d = stable_q;
        db_cnt_d = '0;
        if (p != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = p;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // The FSM looks at the next stable value so the first pulse lands on the
        // same edge the level rises, and a release beats a same-edge terminal count.
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        pulse_d   = 1'b0;
        if (!stable_d) begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pulse_d   = 1'b1;
                    rpt_cnt_d = '0;
                    state_d   = ST_DELAY;
                end
                ST_DELAY: begin
                    if (REPEAT_EN != 0) begin
                        if (rpt_cnt_q == RD_LAST) begin
                            pulse_d   = 1'b1;
                            rpt_cnt_d = '0;
                            state_d   = ST_REPEAT;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (rpt_cnt_q == RR_LAST) begin
                        pulse_d   = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            stable_q  <= 1'b0;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
            state_q   <= ST_IDLE;
            pulse_q   <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            state_q   <= state_d;
            pulse_q   <= pulse_d;
        end
    end

    assign level      = stable_q;
    assign level_next = stable_d;
    assign pulse      = pulse_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - two conditioned keys with conflict detection and pulse masking
module key_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES,
    parameter int REPEAT_EN           = DEFAULT_REPEAT_EN,
    parameter int CNT_W               = DEFAULT_CNT_W
) (
    input  logic iVGA_CLK,
    input  logic reset,
    input  logic iKEY0_raw,
    input  logic iKEY1_raw,
    output logic key0,
    output logic key1,
    output logic key0_pulse,
    output logic key1_pulse,
    output logic conflict
);

    logic lvl0, lvl0_next, pulse0;
    logic lvl1, lvl1_next, pulse1;
    logic conflict_q, conflict_d;

    key_channel #(
        .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
        .REPEAT_EN          (REPEAT_EN),
        .CNT_W              (CNT_W)
    ) u_ch0 (
        .clk       (iVGA_CLK),
        .rst       (reset),
        .key_raw   (iKEY0_raw),
        .level     (lvl0),
        .level_next(lvl0_next),
        .pulse     (pulse0)
    );

    key_channel #(
        .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
        .REPEAT_EN          (REPEAT_EN),
        .CNT_W              (CNT_W)
    ) u_ch1 (
        .clk       (iVGA_CLK),
        .rst       (reset),
        .key_raw   (iKEY1_raw),
        .level     (lvl1),
        .level_next(lvl1_next),
        .pulse     (pulse1)
    );

    always_comb begin
        conflict_d = lvl0_next & lvl1_next;
    end

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    // Conflict updates on the same edge as the levels, so a press completing
    // while the other key is held is masked from its very first pulse.
    assign key0       = lvl0;
    assign key1       = lvl1;
    assign conflict   = conflict_q;
    assign key0_pulse = pulse0 & ~conflict_q;
    assign key1_pulse = pulse1 & ~conflict_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed self-checking bench for key_conditioner
module tb_key_conditioner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic k0_raw, k1_raw, n0_raw, n1_raw;
    logic key0, key1, key0_pulse, key1_pulse, conflict;
    logic nr_key0, nr_key1, nr_key0_pulse, nr_key1_pulse, nr_conflict;

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(8), .REPEAT_RATE_CYCLES(3),
        .REPEAT_EN(1), .CNT_W(24)
    ) dut (
        .iVGA_CLK(clk), .reset(reset), .iKEY0_raw(k0_raw), .iKEY1_raw(k1_raw),
        .key0(key0), .key1(key1), .key0_pulse(key0_pulse), .key1_pulse(key1_pulse),
        .conflict(conflict)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(8), .REPEAT_RATE_CYCLES(3),
        .REPEAT_EN(0), .CNT_W(24)
    ) dut_nr (
        .iVGA_CLK(clk), .reset(reset), .iKEY0_raw(n0_raw), .iKEY1_raw(n1_raw),
        .key0(nr_key0), .key1(nr_key1), .key0_pulse(nr_key0_pulse),
        .key1_pulse(nr_key1_pulse), .conflict(nr_conflict)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    initial begin
        logic seen;
        int   cnt;
        int   glen [4] = '{3, 1, 2, 3};

        reset  = 1'b1;
        k0_raw = 1'b0;
        k1_raw = 1'b1;
        n0_raw = 1'b1;
        n1_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_key0", 32'(key0), 0);
        check("rst_key1", 32'(key1), 0);
        check("rst_key0_pulse", 32'(key0_pulse), 0);
        check("rst_key1_pulse", 32'(key1_pulse), 0);
        check("rst_conflict", 32'(conflict), 0);
        check("rst_nr_key0", 32'(nr_key0), 0);

        // Held through reset: rise at edge 6, repeats 14,17,...; release timed so
        // the fall at edge 38 coincides with a repeat terminal count.
        reset = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            tick();
            check($sformatf("hold_key0_e%0d", e), 32'(key0), 32'(e >= 6 && e < 38));
            check($sformatf("hold_pulse_e%0d", e), 32'(key0_pulse),
                  32'((e == 6) || (e >= 14 && e < 38 && (e - 14) % 3 == 0)));
            if (e == 32) k0_raw = 1'b1;
        end

        foreach (glen[g]) begin
            seen   = 1'b0;
            k1_raw = 1'b0;
            for (int i = 0; i < glen[g]; i++) begin
                tick();
                seen |= key1 | key1_pulse | conflict;
            end
            k1_raw = 1'b1;
            for (int i = 0; i < 8; i++) begin
                tick();
                seen |= key1 | key1_pulse | conflict;
            end
            check($sformatf("glitch_%0d_len%0d", g, glen[g]), 32'(seen), 0);
        end

        // key0 pressed at j=0, key1 at j=10 (rises j=16), key1 released at j=20 (falls j=26)
        k0_raw = 1'b0;
        for (int j = 1; j <= 32; j++) begin
            tick();
            check($sformatf("cf_conflict_j%0d", j), 32'(conflict), 32'(j >= 16 && j < 26));
            check($sformatf("cf_key1_j%0d", j), 32'(key1), 32'(j >= 16 && j < 26));
            check($sformatf("cf_pulse0_j%0d", j), 32'(key0_pulse),
                  32'((j == 6) || (j >= 14 && (j - 14) % 3 == 0 && !(j >= 16 && j < 26))));
            check($sformatf("cf_pulse1_j%0d", j), 32'(key1_pulse), 0);
            if (j == 10) k1_raw = 1'b0;
            if (j == 20) k1_raw = 1'b1;
        end
        k0_raw = 1'b1;
        repeat (10) tick();

        // Reset mid-press then full re-debounce
        k0_raw = 1'b0;
        repeat (10) tick();
        check("pre_rst_key0", 32'(key0), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_key0", 32'(key0), 0);
        check("mid_rst_pulse", 32'(key0_pulse), 0);
        repeat (2) tick();
        reset = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            tick();
            check($sformatf("rerst_key0_j%0d", j), 32'(key0), 32'(j >= 6));
            check($sformatf("rerst_pulse_j%0d", j), 32'(key0_pulse), 32'(j == 6));
        end
        k0_raw = 1'b1;
        repeat (10) tick();

        // Auto-repeat disabled: one pulse per press
        n0_raw = 1'b0;
        cnt    = 0;
        for (int j = 1; j <= 50; j++) begin
            tick();
            cnt += int'(nr_key0_pulse);
            if (j == 6) check("nr_first_pulse_edge", 32'(nr_key0_pulse), 1);
        end
        check("nr_press1_pulses", 32'(cnt), 1);
        check("nr_key0_held", 32'(nr_key0), 1);
        n0_raw = 1'b1;
        repeat (10) tick();
        check("nr_key0_released", 32'(nr_key0), 0);
        n0_raw = 1'b0;
        cnt    = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            cnt += int'(nr_key0_pulse);
        end
        check("nr_press2_pulses", 32'(cnt), 1);
        check("nr_idle_key1", 32'({nr_key1, nr_key1_pulse, nr_conflict}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Input stage directly upstream of vga_controller; drives its key0/key1 inputs, which steer the car.
- Takes the two raw, bouncy, active-low board push-buttons.
- Produces two outputs per key, both active-high "pressed":
  - a synchronized, debounced level;
  - a single-cycle press pulse with hold-to-repeat.
- All logic runs in the iVGA_CLK domain.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive cycles the input must differ from the stable state before the stable state flips (~10 ms at 25 MHz); must be ≥1.
- REPEAT_DELAY_CYCLES, 10000000, cycles from the first press pulse to the first repeat pulse; must be ≥1.
- REPEAT_RATE_CYCLES, 2500000, cycles between subsequent repeat pulses; must be ≥1.
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = one pulse per press only.
- CNT_W, 24, width of every internal counter; must hold the largest cycle parameter.

Ports:
- iVGA_CLK  input  1  pixel clock; sole clock.
- reset  input  1  asynchronous, active-high reset.
- iKEY0_raw  input  1  raw button 0, active-low, asynchronous to iVGA_CLK.
- iKEY1_raw  input  1  raw button 1, active-low, asynchronous to iVGA_CLK.
- key0  output  1  debounced level, 1 = pressed; feeds vga_controller key0.
- key1  output  1  debounced level, 1 = pressed; feeds vga_controller key1.
- key0_pulse  output  1  one-cycle strobe on press and on each repeat.
- key1_pulse  output  1  same, for key 1.
- conflict  output  1  1 while both debounced levels are 1.

Behaviour:
- Reset (async assert, sync release):
  - synchronizer flops preset to 1 (released);
  - stable state = released; all counters = 0; FSMs = IDLE;
  - all outputs = 0.
- Synchronizer: two flops per key (s1, s2). Inversion happens after s2, so the internal signal p = ~s2 is active-high.
- Debounce, per key:
  - Counter increments on every edge where p != stable; it clears on any edge where p == stable.
  - When p != stable and the counter equals DEBOUNCE_CYCLES-1: stable <= p and the counter clears.
  - Latency: if raw is steady from sampling edge k, s2 is valid at edge k+1 and stable flips at edge k+1+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - key0/key1 = the registered stable state.
- Repeat FSM, per key, states IDLE, DELAY, REPEAT; the pulse is registered:
  - IDLE: on the edge where stable goes 0->1, pulse = 1, counter clears. Go to DELAY if REPEAT_EN=1, else REPEAT_WAIT (see below).
  - DELAY: counter increments. When it equals REPEAT_DELAY_CYCLES-1: pulse = 1, counter clears, go to REPEAT.
  - REPEAT: counter increments. When it equals REPEAT_RATE_CYCLES-1: pulse = 1, counter clears, stay.
  - With REPEAT_EN=0, DELAY and REPEAT are unused. The FSM waits in DELAY with the counter frozen (REPEAT_WAIT) until release.
  - In any state, stable = 0 forces IDLE and clears the counter on that edge, with no pulse.
  - A release and a terminal count on the same edge: release wins, no pulse.
- The pulse is exactly one cycle wide; the first pulse appears on the same edge key rises.
- Conflict:
  - conflict = key0 & key1, registered alongside the levels.
  - While conflict = 1, key0_pulse and key1_pulse are forced to 0.
  - The FSMs keep running, so a repeat resumes on its own schedule when one key is released.
  - A press that completes debounce on the same edge the other key is already stable produces no pulse.
  - Simultaneous press of both keys on the same edge: conflict = 1, no pulses.
- Reset mid-press: all state returns to reset values at once. After release, a still-held key must re-debounce fully (DEBOUNCE_CYCLES+2 edges) before key rises again.
- Counter arithmetic is unsigned CNT_W bits and never wraps: every count is bounded by its compare.

Decomposition:
- Package key_pkg:
  - FSM state typedef (IDLE, DELAY, REPEAT; 2-bit encoding);
  - constant KEY_PRESSED_LEVEL = 0 for raw polarity;
  - default cycle constants.
- Sub-module key_channel: synchronizer + debounce + repeat FSM for one key; parameters DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES, REPEAT_EN, CNT_W.
- key_conditioner instantiates key_channel twice and adds the conflict logic and pulse masking.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=8, REPEAT_RATE_CYCLES=3, REPEAT_EN=1):
- Reset asserted with iKEY0_raw=0 held -> all outputs 0 during reset; key0 rises exactly 6 edges after reset release; key0_pulse high for 1 cycle on that edge.
- iKEY1_raw low for 3 cycles, then high; repeat with 1/2/3-cycle glitches -> key1 and key1_pulse stay 0 throughout.
- iKEY0_raw held low for 30 cycles -> pulses at key0 rise edge t, t+8, t+11, t+14, ...; after release, key0 falls 6 edges later and no further pulse appears.
- Press key0, then press key1 10 cycles later -> conflict=1 once key1 is stable; both pulses held at 0; release key1 -> conflict=0, key0 repeats resume at the 3-cycle cadence.
- REPEAT_EN=0, key held for 50 cycles -> exactly one key0_pulse; release and re-press -> exactly one more.
- Release timed so debounce completes on the same edge as a REPEAT terminal count -> FSM goes to IDLE, no pulse on that edge.
